// File: rtl/uart_imem_loader.sv
`default_nettype none
// ============================================================================
// Module   : uart_imem_loader
// Purpose  : UART (8N1) boot loader. Receives "A5 cnt_lo cnt_hi data... chk",
//            writes little-endian 32-bit words into instruction memory and
//            releases the core reset only after the XOR checksum matches.
// Revision : 1.0 - initial release
// ============================================================================
module uart_imem_loader #(
   parameter int         CLKS_PER_BIT = 234,
   parameter int         MEM_WORDS    = 32,
   parameter logic [7:0] CMD_LOAD     = 8'hA5
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        uart_rx,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic        cpu_rst_n,
   output logic        busy,
   output logic        load_err
);

   localparam int            CW      = $clog2(CLKS_PER_BIT + 1);
   localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] CNT_ONE = CW'(1);
   localparam logic [15:0]   MAX_CNT = 16'(MEM_WORDS);

   typedef enum logic [1:0] {
      RX_IDLE  = 2'd0,
      RX_START = 2'd1,
      RX_DATA  = 2'd2,
      RX_STOP  = 2'd3
   } rx_state_t;

   typedef enum logic [2:0] {
      L_IDLE   = 3'd0,
      L_CNT_LO = 3'd1,
      L_CNT_HI = 3'd2,
      L_DATA   = 3'd3,
      L_CHK    = 3'd4,
      L_RUN    = 3'd5,
      L_ERR    = 3'd6
   } ld_state_t;

   // ------------------------------------------------------------------
   // Receiver state
   // ------------------------------------------------------------------
   logic            rx_meta_q, rx_sync_q, rx_prev_q;
   rx_state_t       rx_state_q, rx_state_d;
   logic [CW-1:0]   clk_cnt_q,  clk_cnt_d;
   logic [2:0]      bit_cnt_q,  bit_cnt_d;
   logic [7:0]      shift_q,    shift_d;
   logic            rx_valid_q, rx_valid_d;
   logic [7:0]      rx_byte_q,  rx_byte_d;

   // 2-FF synchronizer plus a delayed copy for falling-edge detection
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_meta_q <= 1'b1;
         rx_sync_q <= 1'b1;
         rx_prev_q <= 1'b1;
      end else begin
         rx_meta_q <= uart_rx;
         rx_sync_q <= rx_meta_q;
         rx_prev_q <= rx_sync_q;
      end
   end

   // Receiver next-state: mid-bit sampling, glitch reject, framing check
   always_comb begin
      rx_state_d = rx_state_q;
      clk_cnt_d  = clk_cnt_q;
      bit_cnt_d  = bit_cnt_q;
      shift_d    = shift_q;
      rx_valid_d = 1'b0;
      rx_byte_d  = rx_byte_q;
      case (rx_state_q)
         RX_IDLE: begin
            // Edge detect (not level) so a low line left by a framing error
            // does not immediately start another frame.
            if (rx_prev_q && !rx_sync_q) begin
               rx_state_d = RX_START;
               clk_cnt_d  = '0;
            end
         end
         RX_START: begin
            if (clk_cnt_q == HALF_M1) begin
               clk_cnt_d = '0;
               if (rx_sync_q) begin
                  rx_state_d = RX_IDLE;
               end else begin
                  rx_state_d = RX_DATA;
                  bit_cnt_d  = 3'd0;
               end
            end else begin
               clk_cnt_d = clk_cnt_q + CNT_ONE;
            end
         end
         RX_DATA: begin
            if (clk_cnt_q == FULL_M1) begin
               clk_cnt_d = '0;
               shift_d   = {rx_sync_q, shift_q[7:1]};
               if (bit_cnt_q == 3'd7) begin
                  rx_state_d = RX_STOP;
               end else begin
                  bit_cnt_d = bit_cnt_q + 3'd1;
               end
            end else begin
               clk_cnt_d = clk_cnt_q + CNT_ONE;
            end
         end
         RX_STOP: begin
            if (clk_cnt_q == FULL_M1) begin
               clk_cnt_d  = '0;
               rx_state_d = RX_IDLE;
               if (rx_sync_q) begin
                  rx_valid_d = 1'b1;
                  rx_byte_d  = shift_q;
               end
            end else begin
               clk_cnt_d = clk_cnt_q + CNT_ONE;
            end
         end
         default: rx_state_d = RX_IDLE;
      endcase
   end

   // Receiver registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_state_q <= RX_IDLE;
         clk_cnt_q  <= '0;
         bit_cnt_q  <= 3'd0;
         shift_q    <= 8'h00;
         rx_valid_q <= 1'b0;
         rx_byte_q  <= 8'h00;
      end else begin
         rx_state_q <= rx_state_d;
         clk_cnt_q  <= clk_cnt_d;
         bit_cnt_q  <= bit_cnt_d;
         shift_q    <= shift_d;
         rx_valid_q <= rx_valid_d;
         rx_byte_q  <= rx_byte_d;
      end
   end

   // ------------------------------------------------------------------
   // Loader state
   // ------------------------------------------------------------------
   ld_state_t   ld_state_q,  ld_state_d;
   logic [15:0] count_q,     count_d;
   logic [15:0] word_idx_q,  word_idx_d;
   logic [1:0]  byte_idx_q,  byte_idx_d;
   logic [7:0]  chk_q,       chk_d;
   logic [23:0] wbuf_q,      wbuf_d;
   logic        mem_we_q,    mem_we_d;
   logic [31:0] mem_addr_q,  mem_addr_d;
   logic [31:0] mem_wdata_q, mem_wdata_d;
   logic        cpu_rst_n_q, cpu_rst_n_d;
   logic        busy_q,      busy_d;
   logic        load_err_q,  load_err_d;
   logic [15:0] count_full_w;

   assign count_full_w = {rx_byte_q, count_q[7:0]};

   // Loader next-state: command/count parse, word assembly, checksum verdict
   always_comb begin
      ld_state_d  = ld_state_q;
      count_d     = count_q;
      word_idx_d  = word_idx_q;
      byte_idx_d  = byte_idx_q;
      chk_d       = chk_q;
      wbuf_d      = wbuf_q;
      mem_we_d    = 1'b0;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      if (rx_valid_q) begin
         case (ld_state_q)
            L_IDLE, L_RUN, L_ERR: begin
               if (rx_byte_q == CMD_LOAD) begin
                  ld_state_d = L_CNT_LO;
                  // Fresh accumulators so a zero-length load checks against 0.
                  word_idx_d = 16'd0;
                  byte_idx_d = 2'd0;
                  chk_d      = 8'h00;
               end
            end
            L_CNT_LO: begin
               count_d    = {8'h00, rx_byte_q};
               ld_state_d = L_CNT_HI;
            end
            L_CNT_HI: begin
               count_d    = count_full_w;
               word_idx_d = 16'd0;
               byte_idx_d = 2'd0;
               chk_d      = 8'h00;
               if (count_full_w > MAX_CNT) begin
                  ld_state_d = L_ERR;
               end else if (count_full_w == 16'd0) begin
                  ld_state_d = L_CHK;
               end else begin
                  ld_state_d = L_DATA;
               end
            end
            L_DATA: begin
               chk_d      = chk_q ^ rx_byte_q;
               byte_idx_d = byte_idx_q + 2'd1;
               case (byte_idx_q)
                  2'd0: wbuf_d[7:0]   = rx_byte_q;
                  2'd1: wbuf_d[15:8]  = rx_byte_q;
                  2'd2: wbuf_d[23:16] = rx_byte_q;
                  default: begin
                     mem_we_d    = 1'b1;
                     mem_addr_d  = {14'd0, word_idx_q, 2'b00};
                     mem_wdata_d = {rx_byte_q, wbuf_q};
                     word_idx_d  = word_idx_q + 16'd1;
                     if (word_idx_q + 16'd1 == count_q) begin
                        ld_state_d = L_CHK;
                     end
                  end
               endcase
            end
            L_CHK: begin
               ld_state_d = (rx_byte_q == chk_q) ? L_RUN : L_ERR;
            end
            default: ld_state_d = L_IDLE;
         endcase
      end
      // Status outputs follow the state being entered so they are aligned
      // with the registered state itself.
      cpu_rst_n_d = (ld_state_d == L_RUN);
      load_err_d  = (ld_state_d == L_ERR);
      busy_d      = !((ld_state_d == L_IDLE) || (ld_state_d == L_RUN) ||
                      (ld_state_d == L_ERR));
   end

   // Loader registers; reset aborts any load and holds the core in reset
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ld_state_q  <= L_IDLE;
         count_q     <= 16'd0;
         word_idx_q  <= 16'd0;
         byte_idx_q  <= 2'd0;
         chk_q       <= 8'h00;
         wbuf_q      <= 24'd0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= 32'd0;
         mem_wdata_q <= 32'd0;
         cpu_rst_n_q <= 1'b0;
         busy_q      <= 1'b0;
         load_err_q  <= 1'b0;
      end else begin
         ld_state_q  <= ld_state_d;
         count_q     <= count_d;
         word_idx_q  <= word_idx_d;
         byte_idx_q  <= byte_idx_d;
         chk_q       <= chk_d;
         wbuf_q      <= wbuf_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         cpu_rst_n_q <= cpu_rst_n_d;
         busy_q      <= busy_d;
         load_err_q  <= load_err_d;
      end
   end

   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign cpu_rst_n = cpu_rst_n_q;
   assign busy      = busy_q;
   assign load_err  = load_err_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_imem_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_imem_loader
// Purpose  : Directed self-checking bench for the UART instruction loader.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_imem_loader;

   localparam int C = 16;   // short bit time keeps the run brief

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        uart_rx = 1'b1;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        cpu_rst_n;
   logic        busy;
   logic        load_err;

   int checks   = 0;
   int failures = 0;
   int wr_n     = 0;
   int base;
   logic [31:0] wr_addr [64];
   logic [31:0] wr_data [64];

   uart_imem_loader #(
      .CLKS_PER_BIT (C),
      .MEM_WORDS    (32),
      .CMD_LOAD     (8'hA5)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .uart_rx   (uart_rx),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .cpu_rst_n (cpu_rst_n),
      .busy      (busy),
      .load_err  (load_err)
   );

   always #5 clk = ~clk;

   // Record every cycle the write strobe is high
   always @(negedge clk) begin
      if (mem_we === 1'b1 && wr_n < 64) begin
         wr_addr[wr_n] <= mem_addr;
         wr_data[wr_n] <= mem_wdata;
         wr_n          <= wr_n + 1;
      end
   end

   task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", name, obs, exp);
      end
   endtask

   // One 8N1 frame, LSB first, then two idle bit times
   task automatic send_frame(input logic [7:0] b, input logic stop);
      uart_rx = 1'b0;
      repeat (C) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         uart_rx = b[i];
         repeat (C) @(negedge clk);
      end
      uart_rx = stop;
      repeat (C) @(negedge clk);
      uart_rx = 1'b1;
      repeat (2 * C) @(negedge clk);
   endtask

   task automatic send_byte(input logic [7:0] b);
      send_frame(b, 1'b1);
   endtask

   task automatic glitch();
      uart_rx = 1'b0;
      repeat (5) @(negedge clk);
      uart_rx = 1'b1;
      repeat (2 * C) @(negedge clk);
   endtask

   // Two-word body: count=2, words 0x00100513 and 0x00200593, then checksum
   task automatic send_body(input logic [7:0] chk);
      send_byte(8'h02); send_byte(8'h00);
      send_byte(8'h13); send_byte(8'h05); send_byte(8'h10); send_byte(8'h00);
      send_byte(8'h93); send_byte(8'h05); send_byte(8'h20); send_byte(8'h00);
      send_byte(chk);
   endtask

   // XOR of 13 05 10 00 93 05 20 00
   localparam logic [7:0] GOOD_CHK = 8'hB0;

   initial begin
      // ---------------- reset state
      rst = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_mem_we",    {31'd0, mem_we},    32'd0);
      check("rst_mem_addr",  mem_addr,           32'd0);
      check("rst_mem_wdata", mem_wdata,          32'd0);
      check("rst_cpu_rst_n", {31'd0, cpu_rst_n}, 32'd0);
      check("rst_busy",      {31'd0, busy},      32'd0);
      check("rst_load_err",  {31'd0, load_err},  32'd0);
      rst = 1'b0;
      repeat (4) @(negedge clk);

      // ---------------- good two-word load
      base = wr_n;
      send_byte(8'hA5);
      check("load_busy_after_cmd", {31'd0, busy},      32'd1);
      check("load_core_held",      {31'd0, cpu_rst_n}, 32'd0);
      send_body(GOOD_CHK);
      check("load_wr_count",  wr_n - base,        32'd2);
      check("load_addr0",     wr_addr[base],      32'h0000_0000);
      check("load_data0",     wr_data[base],      32'h0010_0513);
      check("load_addr1",     wr_addr[base+1],    32'h0000_0004);
      check("load_data1",     wr_data[base+1],    32'h0020_0593);
      check("load_run",       {31'd0, cpu_rst_n}, 32'd1);
      check("load_busy_idle", {31'd0, busy},      32'd0);
      check("load_no_err",    {31'd0, load_err},  32'd0);
      check("hold_addr",      mem_addr,           32'h0000_0004);
      check("hold_wdata",     mem_wdata,          32'h0020_0593);
      check("hold_we_low",    {31'd0, mem_we},    32'd0);

      // ---------------- bad checksum, then recovery
      base = wr_n;
      send_byte(8'hA5);
      check("reload_core_held", {31'd0, cpu_rst_n}, 32'd0);
      send_body(8'h00);
      check("badchk_wr_count", wr_n - base,        32'd2);
      check("badchk_data1",    wr_data[base+1],    32'h0020_0593);
      check("badchk_err",      {31'd0, load_err},  32'd1);
      check("badchk_core",     {31'd0, cpu_rst_n}, 32'd0);
      check("badchk_busy",     {31'd0, busy},      32'd0);
      send_byte(8'hA5);
      check("err_cmd_clears",  {31'd0, load_err},  32'd0);
      check("err_cmd_busy",    {31'd0, busy},      32'd1);
      send_body(GOOD_CHK);
      check("recover_run",     {31'd0, cpu_rst_n}, 32'd1);
      check("recover_no_err",  {31'd0, load_err},  32'd0);

      // ---------------- oversize counts
      base = wr_n;
      send_byte(8'hA5); send_byte(8'h21); send_byte(8'h00);
      check("over33_err",    {31'd0, load_err},  32'd1);
      check("over33_core",   {31'd0, cpu_rst_n}, 32'd0);
      check("over33_writes", wr_n - base,        32'd0);
      send_byte(8'hA5);
      check("over_cmd_clears", {31'd0, load_err}, 32'd0);
      send_byte(8'h00); send_byte(8'h01);
      check("over256_err",   {31'd0, load_err},  32'd1);
      check("over256_writes", wr_n - base,       32'd0);

      // ---------------- zero-length load
      base = wr_n;
      send_byte(8'hA5); send_byte(8'h00); send_byte(8'h00);
      check("zero_busy_chk",  {31'd0, busy},      32'd1);
      send_byte(8'h00);
      check("zero_run",       {31'd0, cpu_rst_n}, 32'd1);
      check("zero_no_err",    {31'd0, load_err},  32'd0);
      check("zero_writes",    wr_n - base,        32'd0);

      // ---------------- glitch and framing error inside a load
      base = wr_n;
      send_byte(8'hA5); send_byte(8'h02); send_byte(8'h00);
      send_byte(8'h13);
      glitch();
      send_byte(8'h05);
      send_frame(8'hFF, 1'b0);
      send_byte(8'h10); send_byte(8'h00);
      send_byte(8'h93); send_byte(8'h05); send_byte(8'h20); send_byte(8'h00);
      send_byte(GOOD_CHK);
      check("noise_wr_count", wr_n - base,        32'd2);
      check("noise_data0",    wr_data[base],      32'h0010_0513);
      check("noise_data1",    wr_data[base+1],    32'h0020_0593);
      check("noise_run",      {31'd0, cpu_rst_n}, 32'd1);
      glitch();
      check("idle_glitch_run", {31'd0, cpu_rst_n}, 32'd1);
      check("idle_glitch_busy", {31'd0, busy},     32'd0);

      // ---------------- new load from RUN, then reset mid-load
      base = wr_n;
      send_byte(8'hA5);
      check("run_cmd_core_held", {31'd0, cpu_rst_n}, 32'd0);
      check("run_cmd_busy",      {31'd0, busy},      32'd1);
      send_byte(8'h02); send_byte(8'h00);
      send_byte(8'h13); send_byte(8'h05); send_byte(8'h10); send_byte(8'h00);
      send_byte(8'h93);
      check("mid_wr_count",  wr_n - base, 32'd1);
      check("mid_wdata_pre", mem_wdata,   32'h0010_0513);
      #2 rst = 1'b1;
      #1;
      check("arst_mem_we",    {31'd0, mem_we},    32'd0);
      check("arst_mem_addr",  mem_addr,           32'd0);
      check("arst_mem_wdata", mem_wdata,          32'd0);
      check("arst_cpu_rst_n", {31'd0, cpu_rst_n}, 32'd0);
      check("arst_busy",      {31'd0, busy},      32'd0);
      check("arst_load_err",  {31'd0, load_err},  32'd0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      repeat (4) @(negedge clk);
      send_byte(8'h05); send_byte(8'h20); send_byte(8'h00); send_byte(GOOD_CHK);
      check("post_rst_writes", wr_n - base,        32'd1);
      check("post_rst_core",   {31'd0, cpu_rst_n}, 32'd0);
      check("post_rst_busy",   {31'd0, busy},      32'd0);
      base = wr_n;
      send_byte(8'hA5);
      send_body(GOOD_CHK);
      check("final_wr_count", wr_n - base,        32'd2);
      check("final_addr1",    wr_addr[base+1],    32'h0000_0004);
      check("final_run",      {31'd0, cpu_rst_n}, 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
